// File: rtl/beat_pkg.sv
// Shared encodings for the beat sequencer: beat/phase one-hots, console phases
// and switch modes, plus the console-phase advance rule applied when a run ends.
package beat_pkg;

  localparam logic [2:0] BEAT_W1 = 3'b001;
  localparam logic [2:0] BEAT_W2 = 3'b010;
  localparam logic [2:0] BEAT_W3 = 3'b100;

  localparam logic [2:0] TPH_IDLE = 3'b000;
  localparam logic [2:0] TPH_T1   = 3'b001;
  localparam logic [2:0] TPH_T2   = 3'b010;
  localparam logic [2:0] TPH_T3   = 3'b100;

  localparam logic [2:0] MODE_RUN  = 3'b000;
  localparam logic [2:0] MODE_WMEM = 3'b001;
  localparam logic [2:0] MODE_RMEM = 3'b010;
  localparam logic [2:0] MODE_RREG = 3'b011;
  localparam logic [2:0] MODE_WREG = 3'b100;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_e;

  // Register writes step one phase per run; memory/run modes jump straight to P2.
  function automatic phase_e phase_after_run(input logic [2:0] mode, input phase_e cur);
    case (mode)
      MODE_WREG:                     return (cur == P0) ? P1 : P2;
      MODE_RUN, MODE_WMEM, MODE_RMEM: return P2;
      default:                       return cur;
    endcase
  endfunction

endpackage

// File: rtl/beat_sequencer_qd_sync_edge.sv
// Synchronises the asynchronous QD pushbutton and emits a one-clock pulse on
// each synchronised rising edge.
module qd_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/beat_sequencer.sv
// Master timing sequencer: QD start, T1/T2/T3 phase ring, W1/W2/W3 beats,
// latched console switches and SSTO/STO console phase flags.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             QD,
  input  logic             DP,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  input  logic             RSWC,
  input  logic             RSWB,
  input  logic             RSWA,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             W1,
  output logic             W2,
  output logic             W3,
  output logic             RUN,
  output logic             SWC,
  output logic             SWB,
  output logic             SWA,
  output logic             SSTO,
  output logic             STO,
  output logic [CNT_W-1:0] BEATCNT
);

  logic             qd_rise;
  logic             start;
  logic [2:0]       rsw;
  logic [2:0]       w_q, w_d;
  logic [2:0]       t_q, t_d;
  logic [2:0]       sw_q, sw_d;
  logic             run_q, run_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  qd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_qd_sync (
    .clk      (CLK),
    .clr_n    (CLR),
    .async_in (QD),
    .rise     (qd_rise)
  );

  assign rsw   = {RSWC, RSWB, RSWA};
  assign start = qd_rise & ~run_q;

  always_comb begin
    w_d     = w_q;
    t_d     = t_q;
    sw_d    = sw_q;
    run_d   = run_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (start) begin
      sw_d  = rsw;
      run_d = 1'b1;
      w_d   = BEAT_W1;
      t_d   = TPH_T1;
      if (rsw != sw_q) phase_d = P0;
    end else if (run_q) begin
      case (t_q)
        TPH_T1: t_d = TPH_T2;
        TPH_T2: t_d = TPH_T3;
        TPH_T3: begin
          cnt_d = cnt_q + CNT_W'(1);
          // STOP/DP override SHORT/LONG and park the beat register on W1.
          if (STOP || DP) begin
            run_d   = 1'b0;
            t_d     = TPH_IDLE;
            w_d     = BEAT_W1;
            phase_d = phase_after_run(sw_q, phase_q);
          end else begin
            t_d = TPH_T1;
            case (w_q)
              BEAT_W1: w_d = SHORT ? BEAT_W1 : BEAT_W2;
              BEAT_W2: w_d = LONG  ? BEAT_W3 : BEAT_W1;
              default: w_d = BEAT_W1;
            endcase
          end
        end
        default: t_d = TPH_T1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      w_q     <= BEAT_W1;
      t_q     <= TPH_IDLE;
      sw_q    <= '0;
      run_q   <= 1'b0;
      phase_q <= P0;
      cnt_q   <= '0;
    end else begin
      w_q     <= w_d;
      t_q     <= t_d;
      sw_q    <= sw_d;
      run_q   <= run_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {T3, T2, T1}    = t_q;
  assign {W3, W2, W1}    = w_q;
  assign RUN             = run_q;
  assign {SWC, SWB, SWA} = sw_q;
  assign SSTO            = (phase_q != P0);
  assign STO             = (phase_q == P2);
  assign BEATCNT         = cnt_q;

endmodule
